// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, IR, memory handshake, decode slices and PC-write control.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TO_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IntMemRead,
  input  logic               IRWrite,
  input  logic               PCWrite,
  input  logic               PCWriteCond,
  input  logic               FlagSel,
  input  logic               PCSrc,
  input  logic [ADDR_W-1:0]  alu_result,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               zero,
  instr_fetch_unit_if.master mem,
  output logic               fetch_stall,
  output logic               fetch_err,
  output logic [ADDR_W-1:0]  pc,
  output logic [3:0]         op,
  output logic [3:0]         rd,
  output logic [3:0]         rs,
  output logic [3:0]         func,
  output logic [7:0]         imm8
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state;
  logic [15:0] ir;
  logic        ack_in_wait;
  logic        expire;
  logic        branch_ok;
  logic        pc_we;

  assign ack_in_wait = (state == S_WAIT) && mem.imem_ack;

`ifdef FETCH_TIMEOUT_EN
  // Counter holds the number of ack-less WAIT cycles already elapsed, so
  // expiry fires on the (2^TO_W-1)th one.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((2 ** TO_W) - 2);
  logic [TO_W-1:0] to_cnt;

  assign expire = (state == S_WAIT) && !mem.imem_ack && (to_cnt == TO_LAST);
`else
  localparam int unused_to_w = TO_W;

  assign expire = 1'b0;
`endif

  assign fetch_err = expire;

  // NOTE: stall is combinational so the control FSM advances on the ack edge itself.
  assign fetch_stall = ((state == S_IDLE) && IntMemRead)
                     | ((state == S_WAIT) && !mem.imem_ack && !expire);

  assign branch_ok = PCWriteCond && (FlagSel ? !zero : zero);
  assign pc_we     = !fetch_stall && !expire && (PCWrite || branch_ok);

  // NOTE: every register below uses <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mem.imem_req  <= 1'b0;
      mem.imem_addr <= '0;
      ir            <= '0;
      pc            <= RESET_PC;
`ifdef FETCH_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      if (pc_we) pc <= PCSrc ? branch_target : alu_result;

      case (state)
        S_IDLE: begin
          if (IntMemRead) begin
            state         <= S_WAIT;
            mem.imem_req  <= 1'b1;
            mem.imem_addr <= pc;
`ifdef FETCH_TIMEOUT_EN
            to_cnt        <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (ack_in_wait) begin
            state        <= S_IDLE;
            mem.imem_req <= 1'b0;
            if (IRWrite) ir <= mem.imem_rdata;
          end else if (expire) begin
            // Load a NOP so the FSM falls back to instruction fetch.
            state        <= S_IDLE;
            mem.imem_req <= 1'b0;
            ir           <= '0;
          end
`ifdef FETCH_TIMEOUT_EN
          else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign op   = ir[15:12];
  assign rd   = ir[11:8];
  assign rs   = ir[7:4];
  assign func = ir[3:0];
  assign imm8 = ir[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_instr_fetch_unit;
  localparam int          ADDR_W   = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef FETCH_TIMEOUT_EN
  localparam int          TO_W     = 4;
`endif

  logic clk = 1'b0;
  logic rst;
  logic IntMemRead, IRWrite, PCWrite, PCWriteCond, FlagSel, PCSrc, zero;
  logic [ADDR_W-1:0] alu_result, branch_target;
  logic fetch_stall, fetch_err;
  logic [ADDR_W-1:0] pc;
  logic [3:0] op, rd, rs, func;
  logic [7:0] imm8;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .IntMemRead(IntMemRead), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .FlagSel(FlagSel), .PCSrc(PCSrc),
    .alu_result(alu_result), .branch_target(branch_target), .zero(zero),
    .mem(bus.master),
    .fetch_stall(fetch_stall), .fetch_err(fetch_err), .pc(pc),
    .op(op), .rd(rd), .rs(rs), .func(func), .imm8(imm8)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch is either in flight or not; while in flight we
  // know which WAIT cycle (1-based) we are in.
  bit                m_valid = 1'b0;
  bit                m_busy;
  int                m_wait_n;
  logic [ADDR_W-1:0] m_pc, m_addr, m_pc_before;
  logic [15:0]       m_ir;
  bit                m_stall_now, m_expire_now;

  function automatic bit m_expire();
`ifdef FETCH_TIMEOUT_EN
    return m_busy && !bus.imem_ack && (m_wait_n == (1 << TO_W) - 1);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_stall();
    if (m_busy) return !bus.imem_ack && !m_expire();
    return IntMemRead;
  endfunction

  always @(posedge clk) begin
    m_stall_now  = m_stall();
    m_expire_now = m_expire();
    if (rst) begin
      m_valid  = 1'b1;
      m_busy   = 1'b0;
      m_wait_n = 0;
      m_pc     = RESET_PC;
      m_addr   = '0;
      m_ir     = '0;
    end else if (m_valid) begin
      m_pc_before = m_pc;
      if (!m_stall_now && !m_expire_now &&
          (PCWrite || (PCWriteCond && (FlagSel ? !zero : zero))))
        m_pc = PCSrc ? branch_target : alu_result;
      if (!m_busy) begin
        if (IntMemRead) begin
          m_busy   = 1'b1;
          m_addr   = m_pc_before;
          m_wait_n = 1;
        end
      end else if (bus.imem_ack) begin
        m_busy = 1'b0;
        if (IRWrite) m_ir = bus.imem_rdata;
      end else if (m_expire_now) begin
        m_busy = 1'b0;
        m_ir   = '0;
      end else begin
        m_wait_n++;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_pc",    32'(pc),            32'(m_pc));
      check("cmp_req",   32'(bus.imem_req),  32'(m_busy));
      check("cmp_addr",  32'(bus.imem_addr), 32'(m_addr));
      check("cmp_ir",    32'({op, rd, rs, func}), 32'(m_ir));
      check("cmp_imm8",  32'(imm8),          32'(m_ir[7:0]));
      check("cmp_stall", 32'(fetch_stall),   32'(m_stall()));
      check("cmp_err",   32'(fetch_err),     32'(m_expire()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; IntMemRead = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0;
    PCWriteCond = 1'b0; FlagSel = 1'b0; PCSrc = 1'b0; zero = 1'b0;
    alu_result = '0; branch_target = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0;
  endtask

  int stall_cnt;

  initial begin
    idle_inputs();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    settle();
    check("rst_pc",   32'(pc), 32'(RESET_PC));
    check("rst_req",  32'(bus.imem_req), 0);
    check("rst_addr", 32'(bus.imem_addr), 0);
    check("rst_ir",   32'({op, rd, rs, func, imm8}), 0);
    check("rst_err",  32'(fetch_err), 0);

    // Minimum-latency fetch with a PC increment alongside.
    IntMemRead = 1'b1; IRWrite = 1'b1; PCWrite = 1'b1; alu_result = 16'h0001;
    bus.imem_rdata = 16'h8123;
    settle();
    check("f1_stall_req_cycle", 32'(fetch_stall), 1);
    cyc();
    bus.imem_ack = 1'b1;
    settle();
    check("f1_stall_ack_cycle", 32'(fetch_stall), 0);
    check("f1_addr", 32'(bus.imem_addr), 0);
    check("f1_pc_held", 32'(pc), 0);
    cyc();
    idle_inputs();
    settle();
    check("f1_op", 32'(op), 8);
    check("f1_rd", 32'(rd), 1);
    check("f1_rs", 32'(rs), 2);
    check("f1_func", 32'(func), 3);
    check("f1_pc", 32'(pc), 1);

    // Ack delayed: IntMemRead held high throughout, rdata noisy until the ack.
    IntMemRead = 1'b1; IRWrite = 1'b1; PCWrite = 1'b1; alu_result = 16'h0002;
    stall_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      bus.imem_rdata = 16'($urandom);
      settle();
      if (fetch_stall) stall_cnt++;
      check("f2_pc_held", 32'(pc), 1);
      check("f2_ir_held", 32'({op, rd, rs, func}), 'h8123);
      if (i > 0) check("f2_addr_stable", 32'(bus.imem_addr), 1);
      cyc();
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hA5C3;
    settle();
    check("f2_stall_ack_cycle", 32'(fetch_stall), 0);
    cyc();
    idle_inputs();
    settle();
    check("f2_stall_cycles", 32'(stall_cnt), 5);
    check("f2_pc", 32'(pc), 2);
    check("f2_ir", 32'({op, rd, rs, func}), 'hA5C3);
    check("f2_req_drop", 32'(bus.imem_req), 0);

    // Conditional branches.
    PCWriteCond = 1'b1; PCSrc = 1'b1; branch_target = 16'h0040; FlagSel = 1'b0; zero = 1'b1;
    cyc();
    check("br_eq_taken", 32'(pc), 'h40);
    PCWriteCond = 1'b0; PCWrite = 1'b1; PCSrc = 1'b0; alu_result = 16'h0010;
    cyc();
    check("jump_pc", 32'(pc), 'h10);
    PCWrite = 1'b0; PCWriteCond = 1'b1; PCSrc = 1'b1; FlagSel = 1'b0; zero = 1'b0;
    cyc();
    check("br_eq_not_taken", 32'(pc), 'h10);
    FlagSel = 1'b1; zero = 1'b0;
    cyc();
    check("br_ne_taken", 32'(pc), 'h40);
    idle_inputs();

    // Reset in the second WAIT cycle, then a late ack.
    IntMemRead = 1'b1; IRWrite = 1'b1;
    cyc();
    IntMemRead = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 16'hFFFF;
    settle();
    check("rw_req", 32'(bus.imem_req), 0);
    check("rw_pc", 32'(pc), 32'(RESET_PC));
    check("rw_ir", 32'({op, rd, rs, func}), 0);
    check("rw_stall", 32'(fetch_stall), 0);
    cyc();
    check("rw_late_ack_ignored", 32'({op, rd, rs, func}), 0);
    idle_inputs();

    // PC wrap: fetch at FFFF while writing 0, then the next fetch uses address 0.
    PCWrite = 1'b1; alu_result = 16'hFFFF;
    cyc();
    check("wrap_pc_max", 32'(pc), 'hFFFF);
    alu_result = 16'h0000; IntMemRead = 1'b1; IRWrite = 1'b1;
    cyc();
    check("wrap_addr_max", 32'(bus.imem_addr), 'hFFFF);
    IntMemRead = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 16'h7777;
    cyc();
    check("wrap_pc_zero", 32'(pc), 0);
    idle_inputs();
    IntMemRead = 1'b1;
    cyc();
    check("wrap_addr_zero", 32'(bus.imem_addr), 0);
    check("wrap_req", 32'(bus.imem_req), 1);
    IntMemRead = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = 16'h7777; IRWrite = 1'b1;
    cyc();
    idle_inputs();

`ifdef FETCH_TIMEOUT_EN
    // Timeout with no ack; PCWrite held to prove the PC does not advance.
    PCWrite = 1'b1; alu_result = 16'h0123;
    cyc();
    alu_result = 16'h0999; IntMemRead = 1'b1; IRWrite = 1'b1;
    cyc();
    IntMemRead = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      settle();
      check("to_err",   32'(fetch_err),   32'(n == 15));
      check("to_stall", 32'(fetch_stall), 32'(n != 15));
      if (n < 15) cyc();
    end
    cyc();
    check("to_req", 32'(bus.imem_req), 0);
    check("to_ir_nop", 32'({op, rd, rs, func}), 0);
    check("to_pc", 32'(pc), 'h0123);
    check("to_err_pulse", 32'(fetch_err), 0);
    PCWrite = 1'b0;
    cyc();

    // Ack on the expiry cycle wins.
    PCWrite = 1'b1; IntMemRead = 1'b1; IRWrite = 1'b1;
    cyc();
    IntMemRead = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      if (n == 15) begin bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1234; end
      settle();
      check("to_ack_err", 32'(fetch_err), 0);
      if (n < 15) cyc();
    end
    cyc();
    check("to_ack_ir", 32'({op, rd, rs, func}), 'h1234);
    check("to_ack_pc", 32'(pc), 'h0999);
    idle_inputs();
`endif

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 500; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      IntMemRead    = 1'($urandom_range(0, 1));
      IRWrite       = ($urandom_range(0, 3) != 0);
      PCWrite       = ($urandom_range(0, 3) == 0);
      PCWriteCond   = ($urandom_range(0, 3) == 0);
      FlagSel       = 1'($urandom_range(0, 1));
      PCSrc         = 1'($urandom_range(0, 1));
      zero          = 1'($urandom_range(0, 1));
      alu_result    = 16'($urandom);
      branch_target = 16'($urandom);
      bus.imem_ack  = ($urandom_range(0, 2) == 0);
      bus.imem_rdata = 16'($urandom);
      cyc();
    end
    idle_inputs();
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Upstream fetch stage of the multicycle core. Owns the program counter and instruction register, and runs the request/acknowledge handshake with instruction memory. Decodes the held instruction into the `op`/`func`/register/immediate fields consumed by the control FSM. Applies the FSM's PC-write controls, including conditional branches, and stalls the FSM while a fetch is outstanding.

## Interface
Parameters:
- `ADDR_W`, default 16: PC and instruction-memory address width.
- `RESET_PC`, default 16'h0000: PC value after reset.
- `TO_W`, default 4: timeout counter width; used only with `FETCH_TIMEOUT_EN`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `IntMemRead` input 1: FSM fetch request.
- `IRWrite` input 1: load IR on fetch completion.
- `PCWrite` input 1: unconditional PC write.
- `PCWriteCond` input 1: conditional PC write.
- `FlagSel` input 1: 0 = branch if `zero`; 1 = branch if `!zero`.
- `PCSrc` input 1: PC next value; 0 = `alu_result`, 1 = `branch_target`.
- `alu_result` input `ADDR_W`: ALU output (PC+1 or jump target).
- `branch_target` input `ADDR_W`: branch target address.
- `zero` input 1: ALU zero flag.
- `imem_req` output 1: memory request, registered.
- `imem_addr` output `ADDR_W`: fetch address, registered.
- `imem_ack` input 1: read data valid.
- `imem_rdata` input 16: instruction word.
- `fetch_stall` output 1: control FSM holds its state while high.
- `fetch_err` output 1: one-cycle pulse on timeout; constant 0 without the macro.
- `pc` output `ADDR_W`: current PC.
- `op` output 4: IR[15:12].
- `rd` output 4: IR[11:8].
- `rs` output 4: IR[7:4].
- `func` output 4: IR[3:0].
- `imm8` output 8: IR[7:0].

## Operation
- States: IDLE, WAIT.
- IDLE → WAIT when `IntMemRead` = 1.
  - Same edge: `imem_addr` <= `pc`, `imem_req` <= 1.
- WAIT → IDLE on the edge where `imem_ack` = 1.
  - `imem_req` <= 0.
  - If `IRWrite` = 1, IR <= `imem_rdata`.
- `IntMemRead` asserted in WAIT is ignored; the request is not duplicated.
- `fetch_stall` = (IDLE & `IntMemRead`) | (WAIT & !`imem_ack`). This is combinational, so the FSM advances on the ack edge.
- PC write enable `pc_we` = !`fetch_stall` & (`PCWrite` | (`PCWriteCond` & (`FlagSel` ? !`zero` : `zero`))).
  - `pc` <= `PCSrc` ? `branch_target` : `alu_result`.
  - PC writes requested while stalled are held off until the stall clears; the FSM keeps its controls asserted.
- PC arithmetic is external; `pc` wraps modulo 2^`ADDR_W` with no overflow flag.
- Decode fields are pure slices of IR and change only on an IR load.
- `imem_ack` in IDLE is ignored.
- Reset outputs:
  - `pc` = `RESET_PC`; IR = 16'h0000, so `op`, `rd`, `rs`, `func`, `imm8` = 0.
  - `imem_req` = 0, `imem_addr` = 0, `fetch_err` = 0, state = IDLE.
- Reset during WAIT: the request drops on the reset edge, and a late ack after reset is ignored.

## Timing
- Minimum fetch = 2 cycles: the request cycle in IDLE, then the WAIT cycle with ack.
  - Each extra ack-wait cycle adds 1.
- IR and decode fields are valid the cycle after the ack edge, which is the FSM's ID state.
- `imem_addr` is stable for the whole WAIT period; `imem_rdata` is sampled only on the ack edge.
- A PC write in a non-stalled cycle is visible on `pc` the next cycle.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A `TO_W`-bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches 2^`TO_W`-1 with no ack: return to IDLE, load IR with 16'h0000 (NOP; the FSM returns to IF), pulse `fetch_err` for 1 cycle, and deassert `fetch_stall` that cycle.
  - PC is not advanced.
  - Ack on the same cycle as expiry wins: normal completion, no error.
- `FETCH_TIMEOUT_EN` undefined: no counter; WAIT persists indefinitely; `fetch_err` tied to 0.

## Test plan
- Reset, then `IntMemRead`=1 with ack one cycle after `imem_req`, `imem_rdata`=16'h8123, `PCWrite`=1, `alu_result`=1:
  - `imem_addr`=0 and `fetch_stall` high for exactly 1 cycle.
  - Then `op`=8, `rd`=1, `rs`=2, `func`=3, `pc`=1.
- Ack delayed 5 cycles:
  - `fetch_stall` high for 5 cycles; `pc` unchanged during the stall.
  - `imem_addr` constant; IR loads only on the ack edge.
- Branch with `PCWriteCond`=1, `PCSrc`=1, `branch_target`=16'h0040:
  - `FlagSel`=0, `zero`=1: `pc`=16'h0040.
  - `FlagSel`=0, `zero`=0: `pc` unchanged.
  - `FlagSel`=1, `zero`=0: `pc`=16'h0040.
- `rst` pulsed in the 2nd WAIT cycle, then ack arrives:
  - `imem_req`=0, `pc`=`RESET_PC`, IR=0, and the ack is ignored.
- `pc`=16'hFFFF with `alu_result`=16'h0000 and `PCWrite`=1: `pc`=0, next `imem_addr`=0.
- With `FETCH_TIMEOUT_EN` and `TO_W`=4, no ack:
  - `fetch_err` pulses on WAIT cycle 15; IR=0; state returns to IDLE; `pc` unchanged.
  - Repeat with ack in cycle 15: normal load, no error.
